// File: rtl/board_token_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_token_writer                                                    |
// | Connect-Four board writer: gravity scan plus frame-synced commits.   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module board_token_writer #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_drop_req,
  input  logic [2:0]                      i_drop_col,
  input  logic [1:0]                      i_drop_player,
  output logic                            o_drop_ready,
  output logic                            o_drop_done,
  output logic                            o_drop_err,
  output logic [2:0]                      o_drop_row,
  input  logic                            i_clear_req,
  output logic                            o_clear_done,
  input  logic                            i_frame_sync,
  output logic [0:ROWS-1][0:COLS-1][1:0]  o_tiles,
  output logic [5:0]                      o_move_count,
  output logic                            o_board_full
);

  localparam logic [5:0] c_CELLS      = 6'(ROWS * COLS);
  localparam logic [2:0] c_ROW_BOTTOM = 3'(ROWS - 1);
  localparam logic [2:0] c_ROW_ERR    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SCAN       = 2'd1,
    S_WAIT_FS    = 2'd2,
    S_CLEAR_WAIT = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_col;
  logic [2:0] r_scan_row;
  logic [1:0] r_player;

  logic       w_accept;
  logic       w_bad_req;
  logic       w_cell_empty;
  logic [5:0] w_count_next;

  assign w_accept     = i_drop_req & o_drop_ready & ~i_clear_req;
  assign w_bad_req    = (int'(i_drop_col) >= COLS) ||
                        ((i_drop_player != 2'd1) && (i_drop_player != 2'd2));
  assign w_cell_empty = (o_tiles[r_scan_row][r_col] == 2'd0);
  assign w_count_next = (o_move_count < c_CELLS) ? o_move_count + 6'd1 : o_move_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= 3'd0;
      r_scan_row   <= 3'd0;
      r_player     <= 2'd0;
      o_drop_ready <= 1'b0;
      o_drop_done  <= 1'b0;
      o_drop_err   <= 1'b0;
      o_drop_row   <= 3'd0;
      o_clear_done <= 1'b0;
      o_tiles      <= '0;
      o_move_count <= 6'd0;
      o_board_full <= 1'b0;
    end else begin
      o_drop_done  <= 1'b0;
      o_drop_err   <= 1'b0;
      o_clear_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_drop_ready <= 1'b1;
          if (i_clear_req) begin
            r_state      <= S_CLEAR_WAIT;
            o_drop_ready <= 1'b0;
          end else if (w_accept) begin
            r_col    <= i_drop_col;
            r_player <= i_drop_player;
            if (w_bad_req) begin
              o_drop_err <= 1'b1;
              o_drop_row <= c_ROW_ERR;
            end else begin
              r_state      <= S_SCAN;
              r_scan_row   <= c_ROW_BOTTOM;
              o_drop_ready <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          // r_scan_row doubles as the target row once an empty cell is found.
          if (w_cell_empty) begin
            r_state <= S_WAIT_FS;
          end else if (r_scan_row == 3'd0) begin
            r_state      <= S_IDLE;
            o_drop_err   <= 1'b1;
            o_drop_row   <= c_ROW_ERR;
            o_drop_ready <= 1'b1;
          end else begin
            r_scan_row <= r_scan_row - 3'd1;
          end
        end
        S_WAIT_FS: begin
          if (i_frame_sync) begin
            o_tiles[r_scan_row][r_col] <= r_player;
            o_move_count <= w_count_next;
            o_board_full <= (w_count_next == c_CELLS);
            o_drop_done  <= 1'b1;
            o_drop_row   <= r_scan_row;
            o_drop_ready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_CLEAR_WAIT: begin
          if (i_frame_sync) begin
            o_tiles      <= '0;
            o_move_count <= 6'd0;
            o_board_full <= 1'b0;
            o_clear_done <= 1'b1;
            o_drop_ready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_token_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_board_token_writer                                                 |
// | Table-driven drops with a pulse scoreboard and a shadow board model. |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_board_token_writer;

  logic                   clk;
  logic                   rst;
  logic                   i_drop_req;
  logic [2:0]             i_drop_col;
  logic [1:0]             i_drop_player;
  logic                   o_drop_ready;
  logic                   o_drop_done;
  logic                   o_drop_err;
  logic [2:0]             o_drop_row;
  logic                   i_clear_req;
  logic                   o_clear_done;
  logic                   i_frame_sync;
  logic [0:5][0:6][1:0]   o_tiles;
  logic [5:0]             o_move_count;
  logic                   o_board_full;

  board_token_writer #(.ROWS(6), .COLS(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_drop_req   (i_drop_req),
    .i_drop_col   (i_drop_col),
    .i_drop_player(i_drop_player),
    .o_drop_ready (o_drop_ready),
    .o_drop_done  (o_drop_done),
    .o_drop_err   (o_drop_err),
    .o_drop_row   (o_drop_row),
    .i_clear_req  (i_clear_req),
    .o_clear_done (o_clear_done),
    .i_frame_sync (i_frame_sync),
    .o_tiles      (o_tiles),
    .o_move_count (o_move_count),
    .o_board_full (o_board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [2:0] row;
  } exp_t;

  typedef struct {
    logic [2:0] col;
    logic [1:0] pl;
    int         fs_at;
    int         early;
    logic       err;
    logic [2:0] row;
  } vec_t;

  int                   total = 0;
  int                   bad   = 0;
  exp_t                 sb[$];
  exp_t                 e;
  logic [0:5][0:6][1:0] m_tiles;
  int                   m_count;
  vec_t                 vt[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every drop_done/drop_err pulse must match the oldest expectation queued.
  always @(negedge clk) begin
    if (!rst && (o_drop_done || o_drop_err)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sb_err", o_drop_err, e.err);
        check("sb_done", o_drop_done, !e.err);
        check("sb_row", o_drop_row, e.row);
      end
    end
  end

  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (o_drop_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) check({name, "_ready_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic drop(input logic [2:0] col, input logic [1:0] pl, input int fs_at,
                      input int early_at, input logic exp_err, input logic [2:0] exp_row,
                      input string name);
    int lat;
    wait_ready(name);
    sb.push_back('{err: exp_err, row: exp_row});
    i_drop_req = 1'b1; i_drop_col = col; i_drop_player = pl;
    @(posedge clk); #1;
    i_drop_req = 1'b0;
    if (exp_err) begin
      lat = (int'(col) >= 7 || (pl != 2'd1 && pl != 2'd2)) ? 1 : 7;
      for (int c = 1; c < lat; c++) begin
        if (c == lat - 1) check({name, "_ready_low_scan"}, o_drop_ready, 1'b0);
        @(posedge clk); #1;
      end
      check({name, "_err_cycle"}, o_drop_err, 1'b1);
      check({name, "_ready_after_err"}, o_drop_ready, 1'b1);
      check({name, "_tiles_unchanged"}, o_tiles, m_tiles);
    end else begin
      for (int c = 1; c <= fs_at; c++) begin
        i_frame_sync = (c == fs_at) || (c == early_at);
        if (c == fs_at) begin
          check({name, "_tiles_before_fs"}, o_tiles, m_tiles);
          check({name, "_ready_before_fs"}, o_drop_ready, 1'b0);
        end
        @(posedge clk); #1;
      end
      i_frame_sync = 1'b0;
      m_tiles[exp_row][col] = pl;
      if (m_count < 42) m_count++;
      check({name, "_done"}, o_drop_done, 1'b1);
      check({name, "_tiles"}, o_tiles, m_tiles);
      check({name, "_count"}, o_move_count, m_count);
      check({name, "_full"}, o_board_full, m_count == 42);
      check({name, "_ready_after"}, o_drop_ready, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    vt[0]  = '{3'd3, 2'd1, 10, 0, 1'b0, 3'd5};
    vt[1]  = '{3'd0, 2'd1,  8, 0, 1'b0, 3'd5};
    vt[2]  = '{3'd0, 2'd2,  8, 0, 1'b0, 3'd4};
    vt[3]  = '{3'd0, 2'd1,  8, 0, 1'b0, 3'd3};
    vt[4]  = '{3'd0, 2'd2,  8, 0, 1'b0, 3'd2};
    vt[5]  = '{3'd0, 2'd1,  8, 0, 1'b0, 3'd1};
    vt[6]  = '{3'd0, 2'd2,  8, 0, 1'b0, 3'd0};
    vt[7]  = '{3'd0, 2'd1,  0, 0, 1'b1, 3'd7};
    vt[8]  = '{3'd7, 2'd1,  0, 0, 1'b1, 3'd7};
    vt[9]  = '{3'd2, 2'd3,  0, 0, 1'b1, 3'd7};
    vt[10] = '{3'd2, 2'd0,  0, 0, 1'b1, 3'd7};
    // frame_sync in SCAN cycles 1..2 (row 4 found in cycle 2) must be ignored
    vt[11] = '{3'd3, 2'd2,  9, 2, 1'b0, 3'd4};

    m_tiles = '0; m_count = 0;
    rst = 1'b1; i_drop_req = 1'b0; i_drop_col = 3'd0; i_drop_player = 2'd0;
    i_clear_req = 1'b0; i_frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_drop_ready, 1'b0);
    check("rst_tiles", o_tiles, m_tiles);
    check("rst_count", o_move_count, 6'd0);
    check("rst_full", o_board_full, 1'b0);
    check("rst_pulses", {o_drop_done, o_drop_err, o_clear_done}, 3'b000);
    check("rst_row", o_drop_row, 3'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", o_drop_ready, 1'b1);

    for (int i = 0; i < 12; i++)
      drop(vt[i].col, vt[i].pl, vt[i].fs_at, vt[i].early, vt[i].err, vt[i].row,
           $sformatf("vec%0d", i));

    for (int c = 0; c < 7; c++) begin
      while (m_tiles[0][c] == 2'd0) begin
        r = 5;
        while (m_tiles[r][c] != 2'd0) r--;
        drop(3'(c), 2'((m_count % 2) + 1), 8, 0, 1'b0, 3'(r), $sformatf("fill_c%0d", c));
      end
    end
    check("full_count", o_move_count, 6'd42);
    check("full_flag", o_board_full, 1'b1);
    drop(3'd4, 2'd1, 0, 0, 1'b1, 3'd7, "drop_on_full");

    wait_ready("clear");
    i_clear_req = 1'b1; i_drop_req = 1'b1; i_drop_col = 3'd1; i_drop_player = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    i_clear_req = 1'b0; i_drop_req = 1'b0;
    check("clear_wait_ready", o_drop_ready, 1'b0);
    check("clear_wait_tiles", o_tiles, m_tiles);
    i_frame_sync = 1'b1;
    @(posedge clk); #1;
    i_frame_sync = 1'b0;
    m_tiles = '0; m_count = 0;
    check("clear_done", o_clear_done, 1'b1);
    check("clear_tiles", o_tiles, m_tiles);
    check("clear_count", o_move_count, 6'd0);
    check("clear_full", o_board_full, 1'b0);
    check("clear_ready", o_drop_ready, 1'b1);

    drop(3'd5, 2'd1, 8, 0, 1'b0, 3'd5, "pre_rst");
    wait_ready("rst_wait_fs");
    i_drop_req = 1'b1; i_drop_col = 3'd5; i_drop_player = 2'd2;
    @(posedge clk); #1;
    i_drop_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; i_frame_sync = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_frame_sync = 1'b0;
    m_tiles = '0; m_count = 0;
    check("midrst_tiles", o_tiles, m_tiles);
    check("midrst_count", o_move_count, 6'd0);
    check("midrst_ready", o_drop_ready, 1'b0);
    @(posedge clk); #1;
    check("midrst_ready_after", o_drop_ready, 1'b1);
    check("midrst_no_done", o_drop_done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
